// File: rtl/param_register_windows.sv
// Parametrised SPARC-style register-window file: NWINDOWS overlapping 24-register
// windows plus 8 globals, with internal CWP/WIM and registered overflow/underflow pulses.
module param_register_windows #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned NWINDOWS = 8
) (
   input  logic                Clk,
   input  logic                Clr,
   output logic [WIDTH-1:0]    PortA,
   output logic [WIDTH-1:0]    PortB,
   input  logic [4:0]          SA,
   input  logic [4:0]          SB,
   input  logic [4:0]          SC,
   input  logic [WIDTH-1:0]    DataIn,
   input  logic                RF_Ld,
   input  logic                Save,
   input  logic                Restore,
   input  logic                Trap,
   input  logic                CWP_Ld,
   input  logic [4:0]          CWP_In,
   input  logic                WIM_Ld,
   input  logic [NWINDOWS-1:0] WIM_In,
   output logic [4:0]          CWP,
   output logic [NWINDOWS-1:0] WIM,
   output logic                OvfTrap,
   output logic                UnfTrap
);

   localparam int unsigned NPHYS = 16 * NWINDOWS;
   localparam int unsigned PW    = $clog2(NPHYS);

   logic [WIDTH-1:0]    win [NPHYS];
   logic [WIDTH-1:0]    glb [8];
   logic [4:0]          cwp_q;
   logic [NWINDOWS-1:0] wim_q;
   logic                ovf_q;
   logic                unf_q;

   logic [4:0]          cwp_dec;
   logic [4:0]          cwp_inc;
   logic                dec_invalid;
   logic                inc_invalid;
   logic                cwp_in_ok;
   logic [PW-1:0]       idx_a;
   logic [PW-1:0]       idx_b;
   logic [PW-1:0]       idx_c;

   // Windowed offset r-8 relative to CWP*16, wrapped over the physical ring.
   function automatic logic [PW-1:0] phys_idx(input logic [4:0] cwp, input logic [4:0] r);
      int unsigned sum;
      sum = 32'(cwp) * 32'd16 + 32'(r) - 32'd8;
      if (sum >= NPHYS) sum = sum - NPHYS;
      return PW'(sum);
   endfunction

   always_comb begin
      cwp_dec     = (cwp_q == 5'd0) ? 5'(NWINDOWS - 1) : cwp_q - 5'd1;
      cwp_inc     = (cwp_q == 5'(NWINDOWS - 1)) ? 5'd0 : cwp_q + 5'd1;
      dec_invalid = |(wim_q & (NWINDOWS'(1) << cwp_dec));
      inc_invalid = |(wim_q & (NWINDOWS'(1) << cwp_inc));
      cwp_in_ok   = (32'(CWP_In) < NWINDOWS);
      idx_a       = phys_idx(cwp_q, SA);
      idx_b       = phys_idx(cwp_q, SB);
      idx_c       = phys_idx(cwp_q, SC);
   end

   // Combinational read ports; r0 is hard-wired to zero.
   always_comb begin
      PortA = '0;
      PortB = '0;
      if (SA[4:3] != 2'b00)      PortA = win[idx_a];
      else if (SA[2:0] != 3'd0)  PortA = glb[SA[2:0]];
      if (SB[4:3] != 2'b00)      PortB = win[idx_b];
      else if (SB[2:0] != 3'd0)  PortB = glb[SB[2:0]];
   end

   // Window control: CWP_Ld > Trap > Save > Restore; WIM checks see pre-edge WIM.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         cwp_q <= '0;
         wim_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         if (WIM_Ld) wim_q <= WIM_In;
         if (CWP_Ld) begin
            if (cwp_in_ok) cwp_q <= CWP_In;
         end else if (Trap) begin
            cwp_q <= cwp_dec;
         end else if (Save) begin
            if (dec_invalid) ovf_q <= 1'b1;
            else             cwp_q <= cwp_dec;
         end else if (Restore) begin
            if (inc_invalid) unf_q <= 1'b1;
            else             cwp_q <= cwp_inc;
         end
      end
   end

   // Register storage; write address decoded with the pre-edge CWP.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         for (int unsigned i = 0; i < NPHYS; i++) win[i] <= '0;
         for (int unsigned i = 0; i < 8; i++)     glb[i] <= '0;
      end else if (RF_Ld) begin
         if (SC[4:3] != 2'b00)      win[idx_c] <= DataIn;
         else if (SC[2:0] != 3'd0)  glb[SC[2:0]] <= DataIn;
      end
   end

   assign CWP     = cwp_q;
   assign WIM     = wim_q;
   assign OvfTrap = ovf_q;
   assign UnfTrap = unf_q;

endmodule

// File: tb/tb_param_register_windows.sv
// Scoreboard bench for param_register_windows: directed plan plus random traffic
// checked against an array-based window model.
module tb_param_register_windows;

   localparam int NW = 8;
   localparam int NP = 16 * NW;

   logic        clk;
   logic        clr, rf_ld, save, restore, trap, cwp_ld, wim_ld;
   logic [4:0]  sa, sb, sc, cwp_in;
   logic [31:0] din;
   logic [7:0]  wim_in;
   logic [31:0] port_a, port_b;
   logic [4:0]  cwp;
   logic [7:0]  wim;
   logic        ovf, unf;

   param_register_windows #(.WIDTH(32), .NWINDOWS(NW)) dut (
      .Clk(clk), .Clr(clr), .PortA(port_a), .PortB(port_b),
      .SA(sa), .SB(sb), .SC(sc), .DataIn(din), .RF_Ld(rf_ld),
      .Save(save), .Restore(restore), .Trap(trap),
      .CWP_Ld(cwp_ld), .CWP_In(cwp_in), .WIM_Ld(wim_ld), .WIM_In(wim_in),
      .CWP(cwp), .WIM(wim), .OvfTrap(ovf), .UnfTrap(unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          clr, rf_ld, save, restore, trap, cwp_ld, wim_ld;
      logic [4:0]  sa, sb, sc, cwp_in;
      logic [7:0]  wim_in;
      logic [31:0] din;
   } stim_t;

   typedef struct {
      logic [31:0] pa, pb;
      logic [4:0]  cwp;
      logic [7:0]  wim;
      bit          ovf, unf;
   } exp_t;

   exp_t  q[$];
   stim_t st;
   int    n_chk  = 0;
   int    n_fail = 0;

   // Reference model state
   logic [31:0] m_phys [NP];
   logic [31:0] m_glb  [8];
   int          m_cwp;
   logic [7:0]  m_wim;
   bit          m_ovf, m_unf;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (a < 5'd8)  return m_glb[a[2:0]];
      return m_phys[(m_cwp * 16 + int'(a) - 8) % NP];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NP; i++) m_phys[i] = 32'd0;
      for (int i = 0; i < 8; i++)  m_glb[i]  = 32'd0;
      m_cwp = 0; m_wim = 8'd0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic model_edge(input stim_t s);
      int dn, up;
      bit novf, nunf;
      if (s.clr) begin
         model_clear();
         return;
      end
      if (s.rf_ld && s.sc != 5'd0) begin
         if (s.sc < 5'd8) m_glb[s.sc[2:0]] = s.din;
         else             m_phys[(m_cwp * 16 + int'(s.sc) - 8) % NP] = s.din;
      end
      dn = (m_cwp + NW - 1) % NW;
      up = (m_cwp + 1) % NW;
      novf = 1'b0; nunf = 1'b0;
      if (s.cwp_ld) begin
         if (int'(s.cwp_in) < NW) m_cwp = int'(s.cwp_in);
      end else if (s.trap) begin
         m_cwp = dn;
      end else if (s.save) begin
         if (m_wim[dn]) novf = 1'b1; else m_cwp = dn;
      end else if (s.restore) begin
         if (m_wim[up]) nunf = 1'b1; else m_cwp = up;
      end
      if (s.wim_ld) m_wim = s.wim_in;
      m_ovf = novf;
      m_unf = nunf;
   endtask

   // Apply staged stimulus after an edge, predict this cycle's outputs, advance model.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      clr = st.clr; rf_ld = st.rf_ld; save = st.save; restore = st.restore;
      trap = st.trap; cwp_ld = st.cwp_ld; wim_ld = st.wim_ld;
      sa = st.sa; sb = st.sb; sc = st.sc; cwp_in = st.cwp_in;
      wim_in = st.wim_in; din = st.din;
      e.pa  = m_read(st.sa);
      e.pb  = m_read(st.sb);
      e.cwp = 5'(m_cwp);
      e.wim = m_wim;
      e.ovf = m_ovf;
      e.unf = m_unf;
      q.push_back(e);
      model_edge(st);
      st = '{default: 0};
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: outputs are valid every cycle; compare at the falling edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("PortA",   port_a,      e.pa);
            chk("PortB",   port_b,      e.pb);
            chk("CWP",     32'(cwp),    32'(e.cwp));
            chk("WIM",     32'(wim),    32'(e.wim));
            chk("OvfTrap", 32'(ovf),    32'(e.ovf));
            chk("UnfTrap", 32'(unf),    32'(e.unf));
         end
      end
   end

   initial begin : driver
      clr = 1'b1; rf_ld = 0; save = 0; restore = 0; trap = 0; cwp_ld = 0; wim_ld = 0;
      sa = '0; sb = '0; sc = '0; cwp_in = '0; wim_in = '0; din = '0;
      st = '{default: 0};
      model_clear();
      repeat (2) @(posedge clk);

      // Reset state
      st.sa = 5'd1; st.sb = 5'd8;  tick();
      st.sa = 5'd31;               tick();

      // Window overlap
      st.rf_ld = 1; st.sc = 5'd8; st.din = 32'hAAAA0001; tick();
      st.save = 1;                tick();
      st.sa = 5'd24;              tick();
      st.restore = 1;             tick();
      st.sa = 5'd8;               tick();

      // Overflow then trap
      st.wim_ld = 1; st.wim_in = 8'h80; tick();
      st.save = 1;                      tick();
      tick();
      st.trap = 1;                      tick();
      tick();

      // Underflow and wrap
      st.cwp_ld = 1; st.cwp_in = 5'd7; st.wim_ld = 1; st.wim_in = 8'h01; tick();
      st.restore = 1; tick();
      tick();
      st.wim_ld = 1; st.wim_in = 8'h00; tick();
      st.restore = 1; tick();
      tick();

      // Simultaneous write/save/restore, then reload CWP and read back
      st.cwp_ld = 1; st.cwp_in = 5'd3; tick();
      st.rf_ld = 1; st.sc = 5'd16; st.din = 32'h1234; st.save = 1; st.restore = 1; tick();
      st.cwp_ld = 1; st.cwp_in = 5'd3; tick();
      st.sa = 5'd16; tick();
      st.cwp_ld = 1; st.cwp_in = 5'd9; tick();
      tick();

      // Globals and r0 across all windows
      st.rf_ld = 1; st.sc = 5'd0; st.din = 32'hFFFF; tick();
      st.rf_ld = 1; st.sc = 5'd5; st.din = 32'h55;   tick();
      for (int i = 0; i < NW; i++) begin
         st.sa = 5'd0; st.sb = 5'd5; st.save = 1; tick();
      end

      // Reset during a save with a pending write
      st.save = 1; st.clr = 1; st.rf_ld = 1; st.sc = 5'd9; st.din = 32'hDEAD; tick();
      st.sa = 5'd9; tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         st.clr     = ($urandom_range(0, 99) == 0);
         st.rf_ld   = ($urandom_range(0, 1) == 0);
         st.save    = ($urandom_range(0, 3) == 0);
         st.restore = ($urandom_range(0, 3) == 0);
         st.trap    = ($urandom_range(0, 15) == 0);
         st.cwp_ld  = ($urandom_range(0, 15) == 0);
         st.wim_ld  = ($urandom_range(0, 15) == 0);
         st.cwp_in  = 5'($urandom_range(0, 11));
         st.wim_in  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'(1 << $urandom_range(0, 7));
         st.sa      = 5'($urandom_range(0, 31));
         st.sb      = 5'($urandom_range(0, 31));
         st.sc      = 5'($urandom_range(0, 31));
         st.din     = $urandom;
         tick();
      end
      tick();

      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/param_register_windows.md
Name: param_register_windows

Overview:
- Parametrised successor to the fixed register-window file used by the SPARC datapath.
- Provides NWINDOWS overlapping windows of 24 registers each, plus 8 globals. r0 always reads 0.
- Owns the CWP and WIM state internally.
- Executes SAVE, RESTORE and trap entry with window overflow/underflow detection. The control unit sees traps as registered pulses rather than decoding PSR/WIM itself.
- Sits between the MuxSa/MuxSc selectors and MuxA/MuxB; written from the ALU output.

Parameters:
- WIDTH, 32, data width of every register and port.
- NWINDOWS, 8, number of windows (2..32). Physical windowed storage is 16*NWINDOWS registers.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Clr  input  1  reset.
- PortA  output  WIDTH  combinational read of register SA.
- PortB  output  WIDTH  combinational read of register SB.
- SA  input  5  read address A.
- SB  input  5  read address B.
- SC  input  5  write address.
- DataIn  input  WIDTH  write data.
- RF_Ld  input  1  write enable.
- Save  input  1  SAVE request.
- Restore  input  1  RESTORE request.
- Trap  input  1  trap entry; CWP decrements with no WIM check.
- CWP_Ld  input  1  load CWP from CWP_In (WRPSR).
- CWP_In  input  5  new CWP.
- WIM_Ld  input  1  load WIM from WIM_In (WRWIM).
- WIM_In  input  NWINDOWS  new WIM.
- CWP  output  5  current window pointer; upper bits zero.
- WIM  output  NWINDOWS  window invalid mask.
- OvfTrap  output  1  one-cycle pulse: SAVE rejected.
- UnfTrap  output  1  one-cycle pulse: RESTORE rejected.

Behaviour:
- **Clock and reset.** There is one clock, Clk. Reset Clr is synchronous and active-high.
- **Reset values (Clr=1 at an edge):**
  - All physical registers are 0.
  - CWP=0, WIM=0, OvfTrap=0, UnfTrap=0.
  - Clr overrides every other input in that cycle.
- **Address map (SA, SB, SC):**
  - r0 reads 0; writes to r0 are discarded.
  - r1..r7 map to globals.
  - For r8..r31, offset o = r-8 (0..23). Physical index = (CWP*16 + o) mod (16*NWINDOWS).
  - So ins (r24..r31) of window w are the outs (r8..r15) of window (w+1) mod NWINDOWS.
- **Reads** are combinational on SA/SB/CWP. There is no write bypass: a write is visible on the cycle after its edge.
- **Writes.** When RF_Ld=1, DataIn is written at the edge. The address is decoded with the CWP value before that edge's update, even if Save/Restore/Trap/CWP_Ld is active in the same cycle.
- **CWP update priority per edge (highest first):**
  1. Clr.
  2. CWP_Ld: CWP<=CWP_In if CWP_In < NWINDOWS. Otherwise CWP is unchanged and no trap is raised.
  3. Trap: CWP<=(CWP-1) mod NWINDOWS, unconditionally.
  4. Save:
     - If WIM[(CWP-1) mod NWINDOWS]=1: CWP unchanged and OvfTrap<=1.
     - Else CWP<=(CWP-1) mod NWINDOWS.
  5. Restore:
     - If WIM[(CWP+1) mod NWINDOWS]=1: CWP unchanged and UnfTrap<=1.
     - Else CWP<=(CWP+1) mod NWINDOWS.
- **Save and Restore together.** If Save=1 and Restore=1 in the same cycle, Save is taken and Restore is ignored.
- **Trap pulse suppression.** Requests suppressed by a higher-priority item raise no trap pulse.
- **Wrap-around.** CWP=0 with Save goes to NWINDOWS-1; CWP=NWINDOWS-1 with Restore goes to 0.
- **WIM checks** use WIM as registered before the edge. WIM_Ld in the same cycle affects only later cycles.
- **WIM.** WIM<=WIM_In when WIM_Ld=1. This is independent of the CWP priority chain.
- **Trap pulses.** OvfTrap/UnfTrap are registered, cleared every cycle they are not re-asserted, and high for exactly one cycle per rejected request.
- **Reset mid-operation.** Clr during a SAVE cycle leaves CWP=0, clears the trap outputs, and discards the write.

Test Plan:
- **Reset.** Hold Clr 2 cycles, then read r1, r8, r31 → all 0; CWP=0, WIM=0, traps 0.
- **Window overlap (NWINDOWS=8).**
  - At CWP=0, write r8=32'hAAAA0001 (physical index 0), then Save → CWP=7.
  - Read r24 → 32'hAAAA0001.
  - Restore → CWP=0; r8 still 32'hAAAA0001.
- **Overflow.**
  - WIM_Ld with WIM_In=8'h80, then at CWP=0 Save → CWP stays 0, OvfTrap high exactly 1 cycle.
  - Then Trap → CWP=7 with no trap.
- **Underflow and wrap.**
  - CWP_Ld with CWP_In=7 and WIM=8'h01, then Restore → CWP=7, UnfTrap pulse.
  - With WIM=0, Restore → CWP=0.
- **Simultaneous events.**
  - At CWP=3: RF_Ld SC=r16, DataIn=32'h1234, with Save=Restore=1 → CWP=2. The value lands at physical index 56 and is read as r16 after CWP_Ld 3.
  - CWP_Ld CWP_In=9 → ignored.
- **Globals and r0.**
  - Write r0=32'hFFFF and r5=32'h55, then cycle CWP through all 8 windows → r0 reads 0 and r5 reads 32'h55 throughout.
- **Mid-operation reset.** Clr during Save → CWP=0, no trap pulse.
